// File: rtl/ram_loader_pkg.sv
// Shared constants and state encoding for the RAM16K program loader.
package ram_loader_pkg;

  localparam int RAM_DEPTH = 8192;
  localparam int ADDR_W    = 13;
  localparam int CNT_W     = 14;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    WORD_HI = 3'd2,
    WORD_LO = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Byte-stream program loader: parses a word-count header, then assembles
// big-endian 16-bit words and writes them into RAM16K from BASE_ADDR upward.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       ram_data,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              done,
  output logic              error,
  output logic              cpu_reset
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR % RAM_DEPTH);

  state_t            state;
  logic [7:0]        hi_byte;
  logic [CNT_W-1:0]  index;
  logic [CNT_W-1:0]  n_words;
  logic [15:0]       hdr_word;
  logic              xfer;
  logic              hdr_bad;

  assign in_ready = (state == HDR_HI) || (state == HDR_LO) ||
                    (state == WORD_HI) || (state == WORD_LO);
  assign xfer     = in_valid && in_ready;
  assign hdr_word = {hi_byte, in_data};
  assign hdr_bad  = (hdr_word == 16'd0) || (hdr_word > 16'(RAM_DEPTH));

  // Write strobe and status are pure state decodes, so reset clears them at once.
  assign ram_load  = (state == WRITE);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_reset = ~done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HDR_HI;
      hi_byte     <= '0;
      index       <= '0;
      n_words     <= '0;
      ram_data    <= '0;
      ram_address <= '0;
    end else begin
      case (state)
        HDR_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            if (hdr_bad) begin
              state <= ERROR;
            end else begin
              n_words <= hdr_word[CNT_W-1:0];
              index   <= '0;
              state   <= WORD_HI;
            end
          end
        end
        WORD_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= WORD_LO;
          end
        end
        WORD_LO: begin
          if (xfer) begin
            ram_data    <= hdr_word;
            // 13-bit add wraps past the top of RAM16K back to address 0.
            ram_address <= BASE_A + index[ADDR_W-1:0];
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (index == n_words - CNT_W'(1)) begin
            state <= DONE;
          end else begin
            index <= index + CNT_W'(1);
            state <= WORD_HI;
          end
        end
        DONE:    state <= DONE;
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: table of header/word streams plus
// hand-written sequences for latency, full-depth load and mid-load reset.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;

  logic        u0_in_ready, u0_ram_load, u0_done, u0_error, u0_cpu_reset;
  logic [15:0] u0_ram_data;
  logic [12:0] u0_ram_address;
  logic        u1_in_ready, u1_ram_load, u1_done, u1_error, u1_cpu_reset;
  logic [15:0] u1_ram_data;
  logic [12:0] u1_ram_address;

  ram_loader #(.BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(u0_in_ready), .ram_data(u0_ram_data), .ram_load(u0_ram_load),
    .ram_address(u0_ram_address), .done(u0_done), .error(u0_error),
    .cpu_reset(u0_cpu_reset)
  );

  ram_loader #(.BASE_ADDR(8191)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(u1_in_ready), .ram_data(u1_ram_data), .ram_load(u1_ram_load),
    .ram_address(u1_ram_address), .done(u1_done), .error(u1_error),
    .cpu_reset(u1_cpu_reset)
  );

  always #5 clk = ~clk;

  logic [15:0] d0_q[$];
  logic [12:0] a0_q[$];
  logic [12:0] a1_q[$];

  always @(negedge clk) begin
    if (u0_ram_load) begin
      d0_q.push_back(u0_ram_data);
      a0_q.push_back(u0_ram_address);
    end
    if (u1_ram_load) a1_q.push_back(u1_ram_address);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0_q.delete();
    a0_q.delete();
    a1_q.delete();
  endtask

  // Present a byte and return on the negedge following its transfer.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waits;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    waits    = 0;
    while (!u0_in_ready && waits < 16) begin
      @(negedge clk);
      waits++;
    end
    if (!u0_in_ready) begin
      tests++;
      fails++;
      $display("FAIL handshake: in_ready stayed 0 for %0d cycles, required 1", waits);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          gaps;
    bit          exp_err;
    int          exp_wr;
    logic [12:0] exp_b0;
    logic [12:0] exp_b1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int errs;
    vecs[0] = '{16'h0002, 16'h1234, 16'hABCD, 1'b0, 1'b0, 2, 13'd8191, 13'd0};
    vecs[1] = '{16'h0002, 16'h1234, 16'hABCD, 1'b1, 1'b0, 2, 13'd8191, 13'd0};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 13'd0,    13'd0};
    vecs[3] = '{16'h2001, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 13'd0,    13'd0};
    vecs[4] = '{16'h0001, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1, 13'd8191, 13'd0};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 13'd0,    13'd0};

    // Reset state
    do_reset();
    chk("rst_in_ready", u0_in_ready, 1);
    chk("rst_ram_load", u0_ram_load, 0);
    chk("rst_ram_data", u0_ram_data, 0);
    chk("rst_ram_addr", u0_ram_address, 0);
    chk("rst_done", u0_done, 0);
    chk("rst_error", u0_error, 0);
    chk("rst_cpu_reset", u0_cpu_reset, 1);

    // Table-driven streams
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send_word(vecs[v].hdr, vecs[v].gaps);
      if (vecs[v].exp_err) begin
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
      end else begin
        send_word(vecs[v].w0, vecs[v].gaps);
        if (vecs[v].exp_wr > 1) send_word(vecs[v].w1, vecs[v].gaps);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_error", v), u0_error, vecs[v].exp_err);
      chk($sformatf("v%0d_done", v), u0_done, !vecs[v].exp_err);
      chk($sformatf("v%0d_cpu_reset", v), u0_cpu_reset, vecs[v].exp_err);
      chk($sformatf("v%0d_in_ready", v), u0_in_ready, 0);
      chk($sformatf("v%0d_nwrites", v), d0_q.size(), vecs[v].exp_wr);
      chk($sformatf("v%0d_nwrites_b", v), a1_q.size(), vecs[v].exp_wr);
      if (d0_q.size() == vecs[v].exp_wr && a1_q.size() == vecs[v].exp_wr) begin
        if (vecs[v].exp_wr > 0) begin
          chk($sformatf("v%0d_data0", v), d0_q[0], vecs[v].w0);
          chk($sformatf("v%0d_addr0", v), a0_q[0], 0);
          chk($sformatf("v%0d_base_addr0", v), a1_q[0], vecs[v].exp_b0);
        end
        if (vecs[v].exp_wr > 1) begin
          chk($sformatf("v%0d_data1", v), d0_q[1], vecs[v].w1);
          chk($sformatf("v%0d_addr1", v), a0_q[1], 1);
          chk($sformatf("v%0d_base_addr1", v), a1_q[1], vecs[v].exp_b1);
        end
      end
    end

    // Write strobe appears the cycle right after the low-byte transfer
    do_reset();
    send_word(16'h0001, 1'b0);
    send_word(16'hBEEF, 1'b0);
    chk("lat_ram_load", u0_ram_load, 1);
    chk("lat_ram_data", u0_ram_data, 16'hBEEF);
    chk("lat_ram_addr", u0_ram_address, 0);
    chk("lat_in_ready", u0_in_ready, 0);
    chk("lat_done_early", u0_done, 0);
    @(negedge clk);
    chk("lat_pulse_end", u0_ram_load, 0);
    chk("lat_done", u0_done, 1);
    chk("lat_cpu_reset", u0_cpu_reset, 0);
    chk("lat_data_hold", u0_ram_data, 16'hBEEF);

    // Full-depth image: 8192 words, index runs to 8191
    do_reset();
    send_word(16'h2000, 1'b0);
    for (int i = 0; i < 8192; i++) send_word(16'(i * 7 + 3), 1'b0);
    repeat (2) @(negedge clk);
    chk("full_error", u0_error, 0);
    chk("full_done", u0_done, 1);
    chk("full_nwrites", d0_q.size(), 8192);
    errs = 0;
    if (d0_q.size() == 8192) begin
      for (int i = 0; i < 8192; i++) begin
        if (a0_q[i] !== 13'(i) || d0_q[i] !== 16'(i * 7 + 3)) errs++;
      end
      chk("full_last_addr", a0_q[8191], 13'd8191);
    end
    chk("full_seq_errs", errs, 0);

    // Reset after WORD_HI transfer, coincident with the low-byte transfer
    do_reset();
    send_word(16'h0002, 1'b0);
    send_byte(8'h12, 1'b0);
    in_data  = 8'h34;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_no_write", d0_q.size(), 0);
    chk("mid_ram_load", u0_ram_load, 0);
    chk("mid_ram_data", u0_ram_data, 0);
    chk("mid_ram_addr", u0_ram_address, 0);
    chk("mid_in_ready", u0_in_ready, 1);
    chk("mid_done", u0_done, 0);
    chk("mid_error", u0_error, 0);
    chk("mid_cpu_reset", u0_cpu_reset, 1);
    @(negedge clk);
    chk("mid_no_write_late", d0_q.size(), 0);
    rst_n = 1'b1;
    send_word(16'h0001, 1'b0);
    send_word(16'h5678, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_reload_n", d0_q.size(), 1);
    if (d0_q.size() == 1 && a1_q.size() == 1) begin
      chk("mid_reload_data", d0_q[0], 16'h5678);
      chk("mid_reload_addr", a0_q[0], 0);
      chk("mid_reload_base", a1_q[0], 13'd8191);
    end
    chk("mid_reload_done", u0_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter BASE_ADDR, 0, first RAM16K word address written; wraps modulo 8192.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 in_data  input  8  incoming program byte, most-significant byte of each word first.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid && in_ready.
REQ-007 ram_data  output  16  assembled word; drives RAM16K data.
REQ-008 ram_load  output  1  single-cycle write strobe; drives RAM16K load.
REQ-009 ram_address  output  13  write address; drives RAM16K address.
REQ-010 done  output  1  image fully written; sticky until reset.
REQ-011 error  output  1  bad header; sticky until reset.
REQ-012 cpu_reset  output  1  holds the CPU in reset; equals NOT done.

Function
REQ-013 Stream format shall be: 16-bit header N (word count), then N 16-bit words; every value high byte first.
REQ-014 FSM states shall be HDR_HI, HDR_LO, WORD_HI, WORD_LO, WRITE, DONE, ERROR.
REQ-015 in_ready shall be 1 in HDR_HI, HDR_LO, WORD_HI and WORD_LO, and 0 in WRITE, DONE and ERROR.
REQ-016 A state shall advance only on a transfer; when in_valid=0 the state and all registers shall hold.
REQ-017 HDR_LO transfer: N=0 or N>8192 shall go to ERROR, otherwise to WORD_HI with word index cleared to 0.
REQ-018 WORD_LO transfer shall latch {high byte, in_data} into ram_data and go to WRITE.
REQ-019 In WRITE, ram_load shall be 1 for exactly one cycle, with ram_address = (BASE_ADDR + index) mod 8192.
REQ-020 Leaving WRITE: if index = N-1, go to DONE; otherwise increment index and go to WORD_HI.
REQ-021 ram_load shall be 0 in every state except WRITE; ram_data and ram_address shall hold between writes.
REQ-022 Latency: ram_load shall assert in the cycle immediately after the low-byte transfer.
REQ-023 Peak throughput: one word per 3 cycles.
REQ-024 Index and N shall be 14 bits wide so that N=8192 is representable; address addition wraps at 13 bits.
REQ-025 DONE and ERROR shall be terminal; later bytes are ignored and in_ready stays 0.
REQ-026 cpu_reset shall be 1 in ERROR.

Reset
REQ-027 With rst_n=0 at a clock edge, state shall become HDR_HI; index, N, ram_data and ram_address become 0; ram_load, done and error become 0; cpu_reset becomes 1.
REQ-028 Reset mid-operation shall abort the load without issuing a write in that cycle; the next stream restarts at the header.
REQ-029 Reset shall take priority over a coincident transfer.

Structure
REQ-030 Package ram_loader_pkg shall hold the state enum, RAM_DEPTH=8192 and ADDR_W=13.
REQ-031 No sub-module is needed: a single FSM with a byte latch, an index counter and an N register.

Verification
REQ-032 Header 0x0002, words 0x1234 and 0xABCD, in_valid held high -> ram_load@0=0x1234, then @1=0xABCD; done=1 and cpu_reset=0 after the second write.
REQ-033 Same stream with in_valid low on alternate cycles -> identical writes, exactly 2 ram_load pulses.
REQ-034 Header 0x0000 -> error=1, in_ready=0, no ram_load, cpu_reset=1.
REQ-035 Header 0x2001 -> error=1; header 0x2000 -> accepted and index reaches 8191.
REQ-036 BASE_ADDR=8191, N=2 -> writes at addresses 8191 then 0.
REQ-037 rst_n=0 after the WORD_HI transfer -> no write issued; outputs match REQ-027; a fresh header/word loads to BASE_ADDR.
